// File: rtl/alarm_ctrl.sv
// Alarm controller: multi-slot alarm matching, BCD snooze with wrap, ring
// auto-timeout and a registered time/alarm display mux.
module alarm_ctrl #(
  parameter int NUM_ALARMS       = 2,
  parameter int ALARM_SEL_W      = 1,
  parameter int SNOOZE_MIN       = 5,
  parameter int RING_TIMEOUT_MIN = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       one_minute,
  input  logic                       snooze,
  input  logic                       stop_alarm,
  input  logic                       show_alarm,
  input  logic [ALARM_SEL_W-1:0]     alarm_sel,
  input  logic [NUM_ALARMS-1:0]      alarm_en,
  input  logic [NUM_ALARMS*16-1:0]   alarm_time,
  input  logic [15:0]                current_time,
  output logic [15:0]                display,
  output logic                       sound_alarm,
  output logic                       snooze_active,
  output logic [ALARM_SEL_W-1:0]     active_alarm
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } state_t;

  // Adds SNOOZE_MIN to a BCD HH:MM value with minute and 24 h wrap.
  function automatic logic [15:0] bcd_add_snooze(input logic [15:0] t);
    logic [7:0] m;
    logic [7:0] h;
    logic       carry;
    logic [3:0] mt, mu, ht, hu;
    m     = 8'(t[7:4]) * 8'd10 + 8'(t[3:0]) + 8'(SNOOZE_MIN);
    h     = 8'(t[15:12]) * 8'd10 + 8'(t[11:8]);
    carry = (m >= 8'd60);
    m     = carry ? (m - 8'd60) : m;
    h     = h + {7'd0, carry};
    h     = (h >= 8'd24) ? 8'd0 : h;
    mt    = 4'(m / 8'd10);
    mu    = 4'(m % 8'd10);
    ht    = 4'(h / 8'd10);
    hu    = 4'(h % 8'd10);
    return {ht, hu, mt, mu};
  endfunction

  state_t                  state_r, state_nx_s;
  logic                    snooze_prev_r, stop_prev_r;
  logic                    snooze_ev_s, stop_ev_s;
  logic [15:0]             snooze_time_r, snooze_time_nx_s;
  logic [6:0]              ring_cnt_r, ring_cnt_nx_s;
  logic [ALARM_SEL_W-1:0]  active_nx_s;
  logic [NUM_ALARMS-1:0]   hit_s;
  logic                    match_s, other_s;
  logic [ALARM_SEL_W-1:0]  match_idx_s, other_idx_s;
  logic [15:0]             disp_slot_s;
  logic                    timeout_s;

  assign snooze_ev_s = snooze & ~snooze_prev_r;
  assign stop_ev_s   = stop_alarm & ~stop_prev_r;
  assign timeout_s   = (RING_TIMEOUT_MIN != 0) &&
                       (({1'b0, ring_cnt_r} + 8'd1) == 8'(RING_TIMEOUT_MIN));

  // Alarm matching; descending scans so the lowest index wins.
  always_comb begin
    hit_s       = {NUM_ALARMS{1'b0}};
    match_s     = 1'b0;
    match_idx_s = {ALARM_SEL_W{1'b0}};
    other_s     = 1'b0;
    other_idx_s = {ALARM_SEL_W{1'b0}};
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      hit_s[i]    = alarm_en[i] && (alarm_time[16*i +: 16] == current_time);
      match_s     = match_s | hit_s[i];
      match_idx_s = hit_s[i] ? ALARM_SEL_W'(i) : match_idx_s;
      other_s     = other_s | (hit_s[i] && (ALARM_SEL_W'(i) != active_alarm));
      other_idx_s = (hit_s[i] && (ALARM_SEL_W'(i) != active_alarm)) ? ALARM_SEL_W'(i) : other_idx_s;
    end
  end

  // Display source select; out-of-range indices fall back to slot 0.
  always_comb begin
    disp_slot_s = alarm_time[15:0];
    for (int i = 0; i < NUM_ALARMS; i++) begin
      disp_slot_s = (alarm_sel == ALARM_SEL_W'(i)) ? alarm_time[16*i +: 16] : disp_slot_s;
    end
  end

  // Next-state logic; stop beats snooze beats the minute tick.
  always_comb begin
    state_nx_s       = state_r;
    snooze_time_nx_s = snooze_time_r;
    ring_cnt_nx_s    = ring_cnt_r;
    active_nx_s      = active_alarm;
    case (state_r)
      IDLE: begin
        if (one_minute && match_s) begin
          state_nx_s    = RINGING;
          active_nx_s   = match_idx_s;
          ring_cnt_nx_s = 7'd0;
        end else begin
          state_nx_s = IDLE;
        end
      end
      RINGING: begin
        if (stop_ev_s) begin
          state_nx_s = IDLE;
        end else if (snooze_ev_s) begin
          state_nx_s       = SNOOZE;
          snooze_time_nx_s = bcd_add_snooze(current_time);
        end else if (one_minute) begin
          ring_cnt_nx_s = (ring_cnt_r == 7'd99) ? ring_cnt_r : (ring_cnt_r + 7'd1);
          state_nx_s    = timeout_s ? IDLE : RINGING;
        end else begin
          state_nx_s = RINGING;
        end
      end
      SNOOZE: begin
        if (stop_ev_s) begin
          state_nx_s       = IDLE;
          snooze_time_nx_s = 16'h0000;
        end else if (one_minute && (current_time == snooze_time_r)) begin
          state_nx_s    = RINGING;
          ring_cnt_nx_s = 7'd0;
        end else if (one_minute && other_s) begin
          state_nx_s    = RINGING;
          active_nx_s   = other_idx_s;
          ring_cnt_nx_s = 7'd0;
        end else begin
          state_nx_s = SNOOZE;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State, button history and snooze/timeout bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      snooze_prev_r <= 1'b1;
      stop_prev_r   <= 1'b1;
      snooze_time_r <= 16'h0000;
      ring_cnt_r    <= 7'd0;
    end else begin
      state_r       <= state_nx_s;
      snooze_prev_r <= snooze;
      stop_prev_r   <= stop_alarm;
      snooze_time_r <= snooze_time_nx_s;
      ring_cnt_r    <= ring_cnt_nx_s;
    end
  end

  // Registered outputs, driven from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      display       <= 16'h0000;
      sound_alarm   <= 1'b0;
      snooze_active <= 1'b0;
      active_alarm  <= {ALARM_SEL_W{1'b0}};
    end else begin
      display       <= show_alarm ? disp_slot_s : current_time;
      sound_alarm   <= (state_nx_s == RINGING);
      snooze_active <= (state_nx_s == SNOOZE);
      active_alarm  <= active_nx_s;
    end
  end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Scoreboard bench for alarm_ctrl: directed stimulus pushes expectations,
// a negedge monitor pops and compares them when they fall due.
module tb_alarm_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, one_minute, snooze, stop_alarm, show_alarm;
  logic [1:0]  alarm_sel;
  logic [2:0]  alarm_en;
  logic [47:0] alarm_time;
  logic [15:0] current_time;
  logic [15:0] display;
  logic        sound_alarm, snooze_active;
  logic [1:0]  active_alarm;

  logic        alarm_sel_b;
  logic [1:0]  alarm_en_b;
  logic [31:0] alarm_time_b;
  logic [15:0] display_b;
  logic        sound_b, snooze_active_b;
  logic        active_b;

  alarm_ctrl #(.NUM_ALARMS(3), .ALARM_SEL_W(2), .SNOOZE_MIN(5), .RING_TIMEOUT_MIN(3)) dut (
    .clk(clk), .rst_n(rst_n), .one_minute(one_minute), .snooze(snooze),
    .stop_alarm(stop_alarm), .show_alarm(show_alarm), .alarm_sel(alarm_sel),
    .alarm_en(alarm_en), .alarm_time(alarm_time), .current_time(current_time),
    .display(display), .sound_alarm(sound_alarm), .snooze_active(snooze_active),
    .active_alarm(active_alarm)
  );

  alarm_ctrl #(.NUM_ALARMS(2), .ALARM_SEL_W(1), .SNOOZE_MIN(5), .RING_TIMEOUT_MIN(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .one_minute(one_minute), .snooze(snooze),
    .stop_alarm(stop_alarm), .show_alarm(show_alarm), .alarm_sel(alarm_sel_b),
    .alarm_en(alarm_en_b), .alarm_time(alarm_time_b), .current_time(current_time),
    .display(display_b), .sound_alarm(sound_b), .snooze_active(snooze_active_b),
    .active_alarm(active_b)
  );

  always #5 clk = ~clk;

  localparam int K_SOUND = 0, K_SNZ = 1, K_ACT = 2, K_DISP = 3, K_SOUND_B = 4;

  typedef struct {
    int          due;
    int          kind;
    logic [15:0] val;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   edges = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  logic [15:0] mon_act;

  always @(posedge clk) edges <= edges + 1;

  function automatic logic [15:0] actual(input int kind);
    case (kind)
      K_SOUND:   return {15'd0, sound_alarm};
      K_SNZ:     return {15'd0, snooze_active};
      K_ACT:     return {14'd0, active_alarm};
      K_DISP:    return display;
      K_SOUND_B: return {15'd0, sound_b};
      default:   return 16'hffff;
    endcase
  endfunction

  // Monitor: compare every expectation that has fallen due.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].due <= edges) begin
      mon_e   = sb_q.pop_front();
      mon_act = actual(mon_e.kind);
      n_checks++;
      if (mon_act !== mon_e.val)
        $display("FAIL %s: got %h expected %h (t=%0t)", mon_e.name, mon_act, mon_e.val, $time);
      else
        n_pass++;
    end
  end

  task automatic exp_chk(input int dly, input int kind, input logic [15:0] val, input string name);
    exp_t e;
    e.due  = edges + dly;
    e.kind = kind;
    e.val  = val;
    e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic end_pulse();
    cyc();
    one_minute = 1'b0;
    cyc();
  endtask

  // Minute pulse at time t with expected sound/snooze one clock later.
  task automatic minute(input logic [15:0] t, input logic s, input logic z, input string name);
    current_time = t;
    one_minute   = 1'b1;
    exp_chk(1, K_SOUND, {15'd0, s}, name);
    exp_chk(1, K_SNZ, {15'd0, z}, name);
    end_pulse();
  endtask

  task automatic press_stop(input string name);
    stop_alarm = 1'b1;
    exp_chk(1, K_SOUND, 16'd0, name);
    exp_chk(1, K_SNZ, 16'd0, name);
    cyc();
    stop_alarm = 1'b0;
    cyc();
  endtask

  task automatic press_snooze(input string name);
    snooze = 1'b1;
    exp_chk(1, K_SOUND, 16'd0, name);
    exp_chk(1, K_SNZ, 16'd1, name);
    cyc();
    snooze = 1'b0;
    cyc();
  endtask

  initial begin
    rst_n = 1'b0; one_minute = 1'b0; snooze = 1'b0; stop_alarm = 1'b0;
    show_alarm = 1'b0; alarm_sel = 2'd0; alarm_en = 3'b000; alarm_time = 48'h0;
    current_time = 16'h0915; alarm_sel_b = 1'b0; alarm_en_b = 2'b00; alarm_time_b = 32'h0;
    repeat (2) cyc();
    exp_chk(0, K_SOUND, 16'd0, "rst_sound");
    exp_chk(0, K_SNZ, 16'd0, "rst_snz");
    exp_chk(0, K_ACT, 16'd0, "rst_active");
    exp_chk(0, K_DISP, 16'h0000, "rst_display");
    n_checks++;
    if (sound_alarm !== 1'b0)
      $display("FAIL rst_sound_direct: got %b", sound_alarm);
    else
      n_pass++;
    n_checks++;
    if (display !== 16'h0000)
      $display("FAIL rst_display_direct: got %h", display);
    else
      n_pass++;
    cyc();
    rst_n = 1'b1;
    repeat (2) cyc();

    // Basic ring and stop
    alarm_time = {16'h0000, 16'h0000, 16'h0730};
    alarm_en   = 3'b001;
    exp_chk(1, K_ACT, 16'd0, "basic_active");
    exp_chk(1, K_DISP, 16'h0730, "disp_current");
    minute(16'h0730, 1'b1, 1'b0, "basic_ring");
    n_checks++;
    if (sound_alarm !== 1'b1)
      $display("FAIL basic_ring_direct: got %b", sound_alarm);
    else
      n_pass++;
    n_checks++;
    if (active_alarm !== 2'd0)
      $display("FAIL basic_active_direct: got %h", active_alarm);
    else
      n_pass++;
    press_stop("basic_stop");
    n_checks++;
    if (sound_alarm !== 1'b0)
      $display("FAIL basic_stop_direct: got %b", sound_alarm);
    else
      n_pass++;

    // Snooze across midnight
    alarm_time = {16'h0000, 16'h0000, 16'h2358};
    minute(16'h2358, 1'b1, 1'b0, "wrap_ring");
    press_snooze("wrap_snooze");
    minute(16'h2359, 1'b0, 1'b1, "wrap_wait_2359");
    minute(16'h0000, 1'b0, 1'b1, "wrap_wait_0000");
    minute(16'h0001, 1'b0, 1'b1, "wrap_wait_0001");
    minute(16'h0002, 1'b0, 1'b1, "wrap_wait_0002");
    exp_chk(1, K_ACT, 16'd0, "wrap_active");
    minute(16'h0003, 1'b1, 1'b0, "wrap_reringing");
    press_stop("wrap_stop");

    // Snooze with hour-digit carry 09:58 -> 10:03
    alarm_time = {16'h0000, 16'h0000, 16'h0958};
    minute(16'h0958, 1'b1, 1'b0, "carry_ring");
    press_snooze("carry_snooze");
    minute(16'h1002, 1'b0, 1'b1, "carry_wait_1002");
    minute(16'h1003, 1'b1, 1'b0, "carry_ring_1003");
    press_stop("carry_stop");

    // Priority: lowest enabled matching index; stop beats snooze
    alarm_time = {16'h0600, 16'h0600, 16'h0600};
    alarm_en   = 3'b110;
    exp_chk(1, K_ACT, 16'd1, "prio_active");
    minute(16'h0600, 1'b1, 1'b0, "prio_ring");
    snooze = 1'b1; stop_alarm = 1'b1;
    exp_chk(1, K_SOUND, 16'd0, "stop_over_snooze_sound");
    exp_chk(1, K_SNZ, 16'd0, "stop_over_snooze_snz");
    cyc();
    snooze = 1'b0; stop_alarm = 1'b0;
    cyc();
    press_stop("idle_stop_noop");
    snooze = 1'b1;
    exp_chk(1, K_SNZ, 16'd0, "idle_snooze_noop");
    cyc();
    snooze = 1'b0;
    cyc();

    // Different alarm cancels snooze
    minute(16'h0600, 1'b1, 1'b0, "other_ring");
    press_snooze("other_snooze");
    alarm_time = {16'h0602, 16'h0600, 16'h0600};
    minute(16'h0601, 1'b0, 1'b1, "other_wait");
    exp_chk(1, K_ACT, 16'd2, "other_active");
    minute(16'h0602, 1'b1, 1'b0, "other_takeover");
    press_stop("other_stop");

    // Ring timeout after three minutes
    alarm_time = {16'h0000, 16'h0000, 16'h0800};
    alarm_en   = 3'b001;
    minute(16'h0800, 1'b1, 1'b0, "tmo_ring");
    minute(16'h0801, 1'b1, 1'b0, "tmo_0801");
    minute(16'h0802, 1'b1, 1'b0, "tmo_0802");
    minute(16'h0803, 1'b0, 1'b0, "tmo_0803_stop");

    // Display mux
    alarm_en   = 3'b000;
    alarm_time = {16'h0602, 16'h1245, 16'h0800};
    show_alarm = 1'b1; alarm_sel = 2'd1;
    exp_chk(1, K_DISP, 16'h1245, "disp_slot1");
    cyc();
    alarm_sel = 2'd3;
    exp_chk(1, K_DISP, 16'h0800, "disp_sel_oob");
    cyc();
    alarm_sel = 2'd2;
    exp_chk(1, K_DISP, 16'h0602, "disp_slot2");
    cyc();
    show_alarm = 1'b0; current_time = 16'h1759;
    exp_chk(1, K_DISP, 16'h1759, "disp_back_current");
    cyc();

    // No timeout when RING_TIMEOUT_MIN = 0
    alarm_time_b = {16'h0000, 16'h0500};
    alarm_en_b   = 2'b01;
    current_time = 16'h0500; one_minute = 1'b1;
    exp_chk(1, K_SOUND_B, 16'd1, "notmo_ring");
    end_pulse();
    alarm_en_b = 2'b00;
    for (int i = 0; i < 120; i++) begin
      current_time = 16'h0501; one_minute = 1'b1;
      end_pulse();
    end
    exp_chk(0, K_SOUND_B, 16'd1, "notmo_after_120");
    exp_chk(0, K_SOUND, 16'd0, "notmo_main_quiet");
    stop_alarm = 1'b1;
    exp_chk(1, K_SOUND_B, 16'd0, "notmo_stop");
    cyc();
    stop_alarm = 1'b0;
    cyc();

    // Async reset while ringing with snooze held
    alarm_time = {16'h0000, 16'h0900, 16'h0000};
    alarm_en   = 3'b010;
    exp_chk(1, K_ACT, 16'd1, "rst2_active_pre");
    minute(16'h0900, 1'b1, 1'b0, "rst2_ring");
    #2;
    rst_n = 1'b0; snooze = 1'b1;
    exp_chk(0, K_SOUND, 16'd0, "rst2_sound");
    exp_chk(0, K_SNZ, 16'd0, "rst2_snz");
    exp_chk(0, K_ACT, 16'd0, "rst2_active");
    exp_chk(0, K_DISP, 16'h0000, "rst2_display");
    cyc();
    rst_n = 1'b1;
    cyc();
    exp_chk(1, K_ACT, 16'd1, "held_active");
    minute(16'h0900, 1'b1, 1'b0, "held_ring");
    exp_chk(1, K_SOUND, 16'd1, "held_no_event_sound");
    exp_chk(1, K_SNZ, 16'd0, "held_no_event_snz");
    cyc();
    snooze = 1'b0;
    cyc();
    press_snooze("held_then_released_snooze");
    press_stop("final_stop");

    begin
      int guard = 0;
      while (sb_q.size() > 0 && guard < 50) begin
        cyc();
        guard++;
      end
    end
    while (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      n_checks++;
      $display("FAIL %s: never checked (due %0d, edges %0d)", mon_e.name, mon_e.due, edges);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alarm_ctrl.md
Name: alarm_ctrl

Overview:
Clocked, parametrised alarm controller for the clock design. It supports NUM_ALARMS independent alarms, a configurable snooze interval with BCD time wrap, and an auto-timeout on ringing. It also drives a registered display mux that selects the current time or a chosen alarm. It sits between the timekeeping counter, which supplies current_time and the one_minute pulse, and the display and buzzer logic.

Parameters:
NUM_ALARMS, 2, number of alarm slots (1..8)
ALARM_SEL_W, 1, width of alarm index ports; 2**ALARM_SEL_W >= NUM_ALARMS
SNOOZE_MIN, 5, snooze interval in minutes (1..59)
RING_TIMEOUT_MIN, 10, minutes of ringing before auto-stop; 0 = ring until stopped (1..99 otherwise)

Ports:
clk  in  1  system clock; all state on rising edge
rst_n  in  1  asynchronous, active-low reset
one_minute  in  1  single-cycle pulse at each minute rollover, synchronous to clk
snooze  in  1  snooze button level, debounced upstream
stop_alarm  in  1  stop button level, debounced upstream
show_alarm  in  1  1 = display selected alarm time, 0 = display current time
alarm_sel  in  ALARM_SEL_W  alarm index for display
alarm_en  in  NUM_ALARMS  per-alarm enable
alarm_time  in  NUM_ALARMS*16  packed BCD HH:MM times; slot i = bits [16i+15:16i]
current_time  in  16  BCD HH:MM {Ht,Hu,Mt,Mu}, 24 h
display  out  16  registered display value
sound_alarm  out  1  registered buzzer enable
snooze_active  out  1  high while in SNOOZE
active_alarm  out  ALARM_SEL_W  index of the alarm that last triggered

Behaviour:
- Reset values (async, immediate): state IDLE; display 16'h0000; sound_alarm 0; snooze_active 0; active_alarm 0; snooze_time 16'h0000; ring_cnt 0.
- Edge-detect registers for snooze and stop reset to 1, so a button held through reset release produces no event.
- snooze_ev / stop_ev = rising edge of snooze / stop_alarm (one clk pulse each).
- match = one_minute and, for some i, alarm_en[i] and alarm_time slot i == current_time.
- If several alarms match, the lowest index wins.
- Same-cycle priority: stop_ev > snooze_ev > one_minute.
- IDLE:
  - On match: go to RINGING; active_alarm <= winning index; ring_cnt <= 0.
  - stop_ev and snooze_ev have no effect.
- RINGING (sound_alarm=1):
  - stop_ev: go to IDLE.
  - snooze_ev: go to SNOOZE; snooze_time <= current_time + SNOOZE_MIN (BCD).
  - one_minute: ring_cnt++; if RING_TIMEOUT_MIN != 0 and ring_cnt+1 == RING_TIMEOUT_MIN, go to IDLE.
  - A new match while ringing is ignored.
- SNOOZE (snooze_active=1, sound_alarm=0):
  - stop_ev: go to IDLE; snooze_time <= 0.
  - snooze_ev: ignored.
  - one_minute with current_time == snooze_time: go to RINGING; ring_cnt <= 0; active_alarm unchanged.
  - Otherwise, a match from a different enabled alarm: go to RINGING with the new active_alarm (snooze cancelled).
- Outputs are registered from the next state. sound_alarm and snooze_active change one clk after the triggering event.
- BCD add:
  - minutes = 10*Mt+Mu+SNOOZE_MIN; if >= 60, subtract 60 and carry 1 hour.
  - Hours carry: 09→10, 19→20, 23→00.
  - Result is always valid BCD for valid input.
- Invalid BCD on inputs: no lock-up; comparison is bitwise; add result unspecified.
- alarm_en changes affect future matches only; deasserting the active alarm's enable does not stop RINGING or SNOOZE.
- Display (one-cycle latency, independent of state):
  - display <= show_alarm ? slot[alarm_sel] : current_time.
  - alarm_sel >= NUM_ALARMS selects slot 0.
- ring_cnt is wide enough for 99 and saturates; it has no effect when RING_TIMEOUT_MIN = 0.
- Reset asserted mid-operation returns to reset values immediately.
- The first stop/snooze edge is recognised only after the button has been seen low once post-reset.

Test Plan:
- Basic ring: alarm0=07:30 enabled, current_time=07:30, pulse one_minute → sound_alarm=1 next clk, active_alarm=0. stop_alarm rise → sound_alarm=0 next clk, state IDLE.
- Snooze wrap: ring at 23:58, snooze rise → snooze_active=1, sound_alarm=0. One_minute pulses at 23:59..00:02 give no ring; pulse at 00:03 → sound_alarm=1, snooze_active=0.
- Priority and multi-alarm: NUM_ALARMS=4, alarms 1 and 3 both 06:00 enabled, alarm 0 06:00 disabled → active_alarm=1. Same-cycle stop and snooze rises → IDLE, not SNOOZE.
- Timeout: RING_TIMEOUT_MIN=3, ring at 08:00 → sound_alarm drops after the third subsequent one_minute (08:03). With RING_TIMEOUT_MIN=0, still ringing after 120 pulses.
- Display: show_alarm=1, alarm_sel=1 with slot1=12:45 → display=16'h1245 one clk later. alarm_sel=3 with NUM_ALARMS=2 → slot0. show_alarm=0 → current_time.
- Reset: assert rst_n=0 while RINGING with snooze held high → all outputs reset asynchronously. After release, no snooze event until the button goes low then high.
